shape_processor_cfg_arbiter: RTL and testbench

Shares the shape processor's single control-SFR access port (write/write_data, read/read_data, error) between NUM_REQ requesters, such as a CPU bridge and a DMA descriptor engine. A round-robin arbiter grants one request at a time. A small FSM issues the bus strobe, captures read_data/error and returns a one-cycle response to the owning requester. Only one SFR access is ever in flight.

---
 rtl/shape_processor_cfg_arbiter.sv | 141 ++++++++++++++
 tb/tb_shape_processor_cfg_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/shape_processor_cfg_arbiter.sv
// Round-robin arbiter that shares one shape-processor control-SFR port between NUM_REQ requesters.
// Define SHAPE_PROCESSOR_CFG_READBACK_EN to read back and compare every write before responding.
module shape_processor_cfg_arbiter #(
  parameter int          NUM_REQ       = 2,
  parameter logic [31:0] READBACK_MASK = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*32-1:0] req_data,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_data,
  output logic                  rsp_error,
  output logic                  rsp_mismatch,
  output logic                  write,
  output logic [31:0]           write_data,
  output logic                  read,
  input  logic [31:0]           read_data,
  input  logic                  error,
  output logic                  busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef SHAPE_PROCESSOR_CFG_READBACK_EN
  localparam bit VERIFY_EN = 1'b1;
`else
  localparam bit VERIFY_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, VERIFY, RESP} state_t;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_found;
  logic               armed;
  logic               accept;
  logic               wr_q;
  logic               err_q;
  logic [31:0]        data_q;
  logic [31:0]        accept_data;
  logic [PTR_W:0]     cand_sum;
  logic [PTR_W-1:0]   cand;
  logic [NUM_REQ-1:0] owner_onehot;

  // First pending requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_sum    = '0;
    cand        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_sum = {1'b0, ptr} + (PTR_W+1)'(i);
      if (cand_sum >= (PTR_W+1)'(NUM_REQ))
        cand_sum = cand_sum - (PTR_W+1)'(NUM_REQ);
      cand = cand_sum[PTR_W-1:0];
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // armed keeps the grant quiet during the first cycle after reset release.
  assign accept       = (state == IDLE) && armed && grant_found;
  assign accept_data  = req_data[{grant_idx, 5'd0} +: 32];
  assign req_ready    = accept ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx) : '0;
  assign owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      owner        <= '0;
      armed        <= 1'b0;
      wr_q         <= 1'b0;
      err_q        <= 1'b0;
      data_q       <= '0;
      write        <= 1'b0;
      write_data   <= '0;
      read         <= 1'b0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
      rsp_error    <= 1'b0;
      rsp_mismatch <= 1'b0;
    end else begin
      armed        <= 1'b1;
      write        <= 1'b0;
      write_data   <= '0;
      read         <= 1'b0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
      rsp_error    <= 1'b0;
      rsp_mismatch <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            owner  <= grant_idx;
            wr_q   <= req_write[grant_idx];
            data_q <= accept_data;
            ptr    <= (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + PTR_W'(1);
            if (req_write[grant_idx]) begin
              write      <= 1'b1;
              write_data <= accept_data;
            end else begin
              read <= 1'b1;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          err_q <= error;
          if (wr_q && VERIFY_EN) begin
            read  <= 1'b1;
            state <= VERIFY;
          end else begin
            rsp_valid <= owner_onehot;
            rsp_data  <= wr_q ? 32'd0 : read_data;
            rsp_error <= error;
            state     <= RESP;
          end
        end
        // Only reachable with readback enabled; the write strobe already happened.
        VERIFY: begin
          rsp_valid    <= owner_onehot;
          rsp_data     <= read_data;
          rsp_error    <= err_q | error;
          rsp_mismatch <= |((read_data ^ data_q) & READBACK_MASK);
          state        <= RESP;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shape_processor_cfg_arbiter.sv
// Scoreboard bench for shape_processor_cfg_arbiter: stimulus pushes expected responses, a monitor pops and checks them.
module tb_shape_processor_cfg_arbiter;

  localparam int N = 2;
`ifdef SHAPE_PROCESSOR_CFG_READBACK_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  req_write = '0;
  logic [N*32-1:0] req_data = '0;
  logic [N-1:0]  rsp_valid;
  logic [31:0]   rsp_data;
  logic          rsp_error;
  logic          rsp_mismatch;
  logic          write;
  logic [31:0]   write_data;
  logic          read;
  logic [31:0]   read_data = '0;
  logic          error = 1'b0;
  logic          busy;

  shape_processor_cfg_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error), .rsp_mismatch(rsp_mismatch),
    .write(write), .write_data(write_data), .read(read), .read_data(read_data),
    .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        err;
    logic        mis;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every cycle, compare any response against the scoreboard head.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      check("strobe_exclusive", {31'd0, write & read}, 32'd0);
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", {30'd0, rsp_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          $display("rsp req=%0d valid=%b data=%h err=%b mis=%b cyc=%0d", e.idx, rsp_valid, rsp_data, rsp_error, rsp_mismatch, cyc);
          check("rsp_valid", {30'd0, rsp_valid}, 32'(1 << e.idx));
          check("rsp_data", rsp_data, e.data);
          check("rsp_error", {31'd0, rsp_error}, {31'd0, e.err});
          check("rsp_mismatch", {31'd0, rsp_mismatch}, {31'd0, e.mis});
          check("rsp_cycle", cyc, e.cyc);
        end
      end else begin
        check("rsp_idle_zero", rsp_data | {30'd0, rsp_error, rsp_mismatch}, 32'd0);
      end
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 12 && busy; k++) begin
      @(posedge clk); #1;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Single access from requester r; vrd/verr are the processor's answer in the readback cycle.
  task automatic do_access(input int r, input bit wr, input logic [31:0] data, input logic [31:0] rd,
                           input bit err, input logic [31:0] vrd, input bit verr);
    bit   got;
    exp_t e;
    @(negedge clk);
    req_write[r] = wr;
    req_data[32*r +: 32] = data;
    req_valid[r] = 1'b1;
    read_data = rd;
    error = err;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      if (req_ready[r]) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid[r] = 1'b0;
      return;
    end
    check("req_ready_onehot", {30'd0, req_ready}, 32'(1 << r));
    e.idx  = r;
    e.data = wr ? (VER ? vrd : 32'd0) : rd;
    e.err  = (VER && wr) ? (err | verr) : err;
    e.mis  = VER && wr && ((vrd ^ data) != 32'd0);
    e.cyc  = cyc + ((VER && wr) ? 3 : 2);
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    check("strobe_write", {31'd0, write}, {31'd0, wr});
    check("strobe_read", {31'd0, read}, {31'd0, !wr});
    if (wr) check("write_data", write_data, data);
    @(posedge clk); #1;
    if (VER && wr) begin
      read_data = vrd;
      error = verr;
      check("verify_read", {30'd0, write, read}, 32'd1);
    end else begin
      error = 1'b0;
      check("strobe_single", {30'd0, write, read}, 32'd0);
    end
    wait_idle();
    error = 1'b0;
    read_data = '0;
  endtask

  // Both requesters contend; each wants n_each accesses. Starts with ptr at 0.
  task automatic run_pair(input int n_each, input bit wr);
    int rem[2];
    int last_t;
    int last_g;
    int nacc;
    int g;
    exp_t e;
    rem[0] = n_each; rem[1] = n_each;
    last_t = -1; last_g = -1; nacc = 0; g = 0;
    @(negedge clk);
    req_write = {wr, wr};
    req_data = {32'h0000_0C00, 32'h0000_0C00};
    read_data = 32'h0000_0C00;
    error = 1'b0;
    req_valid = 2'b11;
    for (int k = 0; k < 80 && nacc < 2*n_each; k++) begin
      #1;
      if (req_ready != '0) begin
        g = req_ready[1] ? 1 : 0;
        check("rr_order", g, (last_g < 0) ? 0 : 1 - last_g);
        if (last_t >= 0) check("accept_spacing", cyc - last_t, (wr && VER) ? 4 : 3);
        e.idx = g;
        e.data = (wr && !VER) ? 32'd0 : 32'h0000_0C00;
        e.err = 1'b0;
        e.mis = 1'b0;
        e.cyc = cyc + ((wr && VER) ? 3 : 2);
        sb.push_back(e);
        last_t = cyc; last_g = g; nacc++; rem[g]--;
        @(posedge clk); #1;
        if (rem[g] == 0) req_valid[g] = 1'b0;
      end
      @(negedge clk);
    end
    check("pair_accepts", nacc, 2*n_each);
    req_valid = '0;
    #1;
    wait_idle();
    read_data = '0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", {23'd0, req_ready, write, read, rsp_valid, busy, rsp_error, rsp_mismatch}, 32'd0);
    check("reset_wdata", write_data | rsp_data, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_access(0, 1'b1, 32'h0000_0012, 32'd0, 1'b0, 32'h0000_0012, 1'b0);
    do_access(1, 1'b0, 32'd0, 32'h0000_0034, 1'b0, 32'd0, 1'b0);
    run_pair(2, 1'b1);
    do_access(0, 1'b1, 32'h0000_00FF, 32'd0, 1'b0, 32'h0000_0012, 1'b0);
    do_access(1, 1'b1, 32'h0000_00FF, 32'd0, 1'b1, 32'h0000_00FF, 1'b0);
    do_access(0, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'hFFFF_FFFF, 1'b0);
    do_access(0, 1'b0, 32'd0, 32'h0000_0001, 1'b1, 32'd0, 1'b0);

    // Error outside any strobe must not leak into the next response.
    @(negedge clk);
    error = 1'b1;
    repeat (3) @(negedge clk);
    error = 1'b0;
    do_access(1, 1'b0, 32'd0, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b0);

    // Reset during ISSUE: requester 0 granted (ptr moves to 1), then reset drops everything.
    @(negedge clk);
    req_write[0] = 1'b1;
    req_data[31:0] = 32'h0000_005A;
    req_valid[0] = 1'b1;
    #1;
    check("rst_pre_accept", {30'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("rst_pre_write", {31'd0, write}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_drop", {26'd0, write, read, rsp_valid, req_ready}, 32'd0);
    @(negedge clk);
    req_valid = 2'b11;
    req_write = 2'b00;
    rst_n = 1'b1;
    #1;
    check("rst_first_cycle_quiet", {29'd0, req_ready, busy}, 32'd0);
    @(negedge clk);
    req_valid = 2'b00;
    run_pair(1, 1'b0);

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
